// File: rtl/cron_regressivo_if.sv
`default_nettype none
// ============================================================================
// Module      : cron_regressivo_if
// Description : Control/status bundle of the countdown timer. The controller
//               side (master) drives load/preset/play_pause; the timer side
//               (slave) drives the remaining-seconds value and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface cron_regressivo_if;
    logic       load;
    logic [9:0] preset;
    logic       play_pause;
    logic [9:0] q;
    logic       tick_1s;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output load, preset, play_pause,
        input  q, tick_1s, running, done, expired
    );

    modport slave (
        input  load, preset, play_pause,
        output q, tick_1s, running, done, expired
    );
endinterface
`default_nettype wire

// File: rtl/cron_regressivo.sv
`default_nettype none
// ============================================================================
// Module      : cron_regressivo
// Description : 0-999 second countdown timer. Loads a clamped preset, counts
//               down once per TICK_DIV clocks while running, supports
//               pause/resume with partial-second preservation, and flags
//               expiry with a held level (done) and a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cron_regressivo #(
    parameter int TICK_DIV = 50_000_000
) (
    input  wire               clk,
    input  wire               rst_n,
    cron_regressivo_if.slave  bus
);

    localparam int             c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);
    localparam logic [9:0]      c_Q_MAX     = 10'd999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [9:0]      r_q;
    logic [9:0]      w_q_n;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_n;
    logic            r_running;
    logic            r_done;
    logic            r_expired;
    logic            w_expired_n;
    logic            w_tick;
    logic [9:0]      w_clamped;

    // Second boundary: last prescaler count while actually running.
    assign w_tick    = (r_state == RUN) && (r_presc == c_PRESC_MAX);
    assign w_clamped = (bus.preset > c_Q_MAX) ? c_Q_MAX : bus.preset;

    // State, counters and registered status flags; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_q       <= 10'd0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_q       <= w_q_n;
            r_presc   <= w_presc_n;
            r_running <= (w_state_n == RUN);
            r_done    <= (w_state_n == EXPIRED);
            r_expired <= w_expired_n;
        end
    end

    // Next-state and datapath decisions; every register holds unless told otherwise.
    always_comb begin
        w_state_n   = r_state;
        w_q_n       = r_q;
        w_presc_n   = r_presc;
        w_expired_n = 1'b0;
        case (r_state)
            IDLE: begin
                // Load takes priority; a start request is re-evaluated next
                // cycle against the freshly loaded value.
                if (bus.load) begin
                    w_q_n     = w_clamped;
                    w_presc_n = '0;
                end else if (bus.play_pause && (r_q != 10'd0)) begin
                    w_state_n = RUN;
                    w_presc_n = '0;
                end
            end
            RUN: begin
                w_presc_n = w_tick ? '0 : (r_presc + c_PRESC_ONE);
                if (w_tick) begin
                    if (r_q == 10'd1) begin
                        // Final second wins over a simultaneous pause request.
                        w_q_n       = 10'd0;
                        w_state_n   = EXPIRED;
                        w_expired_n = 1'b1;
                    end else begin
                        w_q_n = r_q - 10'd1;
                        if (!bus.play_pause) begin
                            w_state_n = PAUSE;
                        end
                    end
                end else if (!bus.play_pause) begin
                    w_state_n = PAUSE;
                end
            end
            PAUSE: begin
                // Prescaler stays frozen so a resume keeps the partial second.
                if (bus.load) begin
                    w_q_n     = w_clamped;
                    w_presc_n = '0;
                    w_state_n = IDLE;
                end else if (bus.play_pause) begin
                    w_state_n = RUN;
                end
            end
            EXPIRED: begin
                w_q_n = 10'd0;
                if (bus.load) begin
                    w_q_n     = w_clamped;
                    w_presc_n = '0;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign bus.q       = r_q;
    assign bus.tick_1s = w_tick;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.expired = r_expired;

endmodule
`default_nettype wire
